alu_req_arbiter: RTL and testbench

ALU_REQ_ARBITER -- requirements
Module: alu_req_arbiter

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_req_arbiter.sv | 131 +++++++++++++
 tb/tb_alu_req_arbiter.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU request arbiter and the external shared ALU:
// operand/result widths, op_code constants and the arbiter FSM state type.
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int unsigned OperandWidth = 4;
    localparam int unsigned ResultWidth  = 5;
    localparam int unsigned OpWidth      = 3;

    // op_code values understood by the shared ALU. 3'b111 is not named here
    // but is still passed through untouched by the arbiter.
    localparam logic [OpWidth-1:0] OpAdd = 3'b000;
    localparam logic [OpWidth-1:0] OpSub = 3'b001;
    localparam logic [OpWidth-1:0] OpAnd = 3'b010;
    localparam logic [OpWidth-1:0] OpOr  = 3'b011;
    localparam logic [OpWidth-1:0] OpXor = 3'b100;
    localparam logic [OpWidth-1:0] OpShl = 3'b101;
    localparam logic [OpWidth-1:0] OpShr = 3'b110;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StExec = 2'b01,
        StCapt = 2'b10,
        StResp = 2'b11
    } arb_state_e;

endpackage

// File: rtl/alu_req_arbiter.sv
// -----------------------------------------------------------------------------
// alu_req_arbiter
// Round-robin arbiter that shares one external, registered ALU between two
// requesters. One operation is in flight at a time: IDLE (grant) -> EXEC (ALU
// computes) -> CAPT (ALU result captured) -> RESP (one-cycle response pulse).
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   reqN_valid/a/b/op          requester N operation and operands (N = 0, 1)
//   reqN_ready                 requester N accepted this cycle (IDLE only)
//   alu_a, alu_b, alu_op       operands held for the shared ALU
//   alu_result, alu_zero       registered ALU outputs
//   respN_valid                one-cycle response pulse for requester N
//   resp_result, resp_zero     captured ALU result, held until next capture
// -----------------------------------------------------------------------------
module alu_req_arbiter
    import alu_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    req0_valid,
    input  logic [OperandWidth-1:0] req0_a,
    input  logic [OperandWidth-1:0] req0_b,
    input  logic [OpWidth-1:0]      req0_op,
    output logic                    req0_ready,

    input  logic                    req1_valid,
    input  logic [OperandWidth-1:0] req1_a,
    input  logic [OperandWidth-1:0] req1_b,
    input  logic [OpWidth-1:0]      req1_op,
    output logic                    req1_ready,

    output logic [OperandWidth-1:0] alu_a,
    output logic [OperandWidth-1:0] alu_b,
    output logic [OpWidth-1:0]      alu_op,
    input  logic [ResultWidth-1:0]  alu_result,
    input  logic                    alu_zero,

    output logic                    resp0_valid,
    output logic                    resp1_valid,
    output logic [ResultWidth-1:0]  resp_result,
    output logic                    resp_zero
);

    arb_state_e                state_q, state_d;
    logic                      last_grant_q;
    logic                      grant_id_q;
    logic [OperandWidth-1:0]   alu_a_q, alu_b_q;
    logic [OpWidth-1:0]        alu_op_q;
    logic [ResultWidth-1:0]    resp_result_q;
    logic                      resp_zero_q;

    logic                      grant;
    logic                      accept;

    // Grant selection: a lone requester always wins; under contention the
    // requester that was not granted last time wins.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant_q;
        end else begin
            grant = req1_valid;
        end
    end

    assign accept = (state_q == StIdle) && (req0_valid || req1_valid);

    // Gated with rst_n so ready stays low while reset holds the FSM in IDLE.
    assign req0_ready = rst_n && accept && !grant;
    assign req1_ready = rst_n && accept &&  grant;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept) state_d = StExec;
            StExec: state_d = StCapt;
            StCapt: state_d = StResp;
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand latch and grant bookkeeping; only an acceptance moves these,
    // so valid toggling outside IDLE leaves priority untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
            grant_id_q   <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
        end else if (accept) begin
            last_grant_q <= grant;
            grant_id_q   <= grant;
            alu_a_q      <= grant ? req1_a  : req0_a;
            alu_b_q      <= grant ? req1_b  : req0_b;
            alu_op_q     <= grant ? req1_op : req0_op;
        end
    end

    // The ALU registers its result at the EXEC->CAPT edge; sample it on the
    // CAPT->RESP edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_result_q <= '0;
            resp_zero_q   <= 1'b0;
        end else if (state_q == StCapt) begin
            resp_result_q <= alu_result;
            resp_zero_q   <= alu_zero;
        end
    end

    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_op      = alu_op_q;
    assign resp_result = resp_result_q;
    assign resp_zero   = resp_zero_q;
    assign resp0_valid = (state_q == StResp) && !grant_id_q;
    assign resp1_valid = (state_q == StResp) &&  grant_id_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_req_arbiter
// Directed bench for alu_req_arbiter with a small registered ALU model beside
// the DUT. Inputs change #1 after a rising edge; outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_alu_req_arbiter;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req1_valid;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0] req0_op, req1_op;
    logic       req0_ready, req1_ready;
    logic [3:0] alu_a, alu_b;
    logic [2:0] alu_op;
    logic [4:0] alu_result;
    logic       alu_zero;
    logic       resp0_valid, resp1_valid;
    logic [4:0] resp_result;
    logic       resp_zero;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int t0, t1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_req_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_valid  (req0_valid),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req0_op     (req0_op),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .req1_op     (req1_op),
        .req1_ready  (req1_ready),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero),
        .resp0_valid (resp0_valid),
        .resp1_valid (resp1_valid),
        .resp_result (resp_result),
        .resp_zero   (resp_zero)
    );

    // Shared ALU model: result registered one edge after operands are presented.
    logic [4:0] alu_comb;
    always_comb begin
        alu_comb = '0;
        case (alu_op)
            OpAdd: alu_comb = {1'b0, alu_a} + {1'b0, alu_b};
            OpSub: alu_comb = {1'b0, alu_a} - {1'b0, alu_b};
            OpAnd: alu_comb = {1'b0, alu_a & alu_b};
            OpOr:  alu_comb = {1'b0, alu_a | alu_b};
            OpXor: alu_comb = {1'b0, alu_a ^ alu_b};
            OpShl: alu_comb = {1'b0, alu_a} << alu_b;
            OpShr: alu_comb = {1'b0, alu_a} >> alu_b;
            default: alu_comb = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_result <= '0;
            alu_zero   <= 1'b0;
        end else begin
            alu_result <= alu_comb;
            alu_zero   <= (alu_comb == 5'd0);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Walks one operation through IDLE/EXEC/CAPT/RESP with fixed latency.
    // Called #1 after a rising edge with requester inputs already driven.
    task automatic serve(input string tag, input int id, input logic [3:0] a,
                         input logic [3:0] b, input logic [2:0] op, input logic [4:0] res,
                         input logic zero, input logic drop, output int resp_cyc);
        @(negedge clk);
        check_eq({tag, "_rdy0"}, req0_ready, (id == 0));
        check_eq({tag, "_rdy1"}, req1_ready, (id == 1));
        @(posedge clk);
        #1;
        if (drop) begin
            if (id == 0) req0_valid = 1'b0;
            else         req1_valid = 1'b0;
        end
        @(negedge clk);
        check_eq({tag, "_exec_rdy"}, {req0_ready, req1_ready}, 2'b00);
        check_eq({tag, "_alu_in"}, {alu_a, alu_b, alu_op}, {a, b, op});
        @(negedge clk);
        check_eq({tag, "_capt_rdy"}, {req0_ready, req1_ready}, 2'b00);
        check_eq({tag, "_capt_resp"}, {resp0_valid, resp1_valid}, 2'b00);
        @(negedge clk);
        check_eq({tag, "_resp_v"}, {resp0_valid, resp1_valid}, (id == 0) ? 2'b10 : 2'b01);
        check_eq({tag, "_resp_rdy"}, {req0_ready, req1_ready}, 2'b00);
        check_eq({tag, "_result"}, resp_result, res);
        check_eq({tag, "_zero"}, resp_zero, zero);
        resp_cyc = cyc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        req0_a = '0; req0_b = '0; req0_op = '0;
        req1_a = '0; req1_b = '0; req1_op = '0;
        do_reset();

        @(negedge clk);
        check_eq("rst_outs", {alu_a, alu_b, alu_op, resp_result, resp_zero}, '0);
        check_eq("rst_pulses", {req0_ready, req1_ready, resp0_valid, resp1_valid}, 4'b0000);
        @(posedge clk);
        #1;

        // Single requester 0: 3 + 2 = 5, response 3 cycles after ready.
        req0_valid = 1'b1; req0_a = 4'd3; req0_b = 4'd2; req0_op = OpAdd;
        serve("r0_add", 0, 4'd3, 4'd2, OpAdd, 5'd5, 1'b0, 1'b1, t0);
        @(negedge clk);
        check_eq("r0_add_pulse_end", {resp0_valid, resp1_valid}, 2'b00);
        @(posedge clk);
        #1;

        // Contention straight after reset: req0 first, req1 four cycles later.
        do_reset();
        req0_valid = 1'b1; req0_a = 4'd7;  req0_b = 4'd2;  req0_op = OpSub;
        req1_valid = 1'b1; req1_a = 4'd12; req1_b = 4'd10; req1_op = OpAnd;
        serve("both_r0", 0, 4'd7, 4'd2, OpSub, 5'd5, 1'b0, 1'b1, t0);
        serve("both_r1", 1, 4'd12, 4'd10, OpAnd, 5'd8, 1'b0, 1'b1, t1);
        check_eq("both_gap", t1 - t0, 4);

        // Both valid continuously: grants alternate 0,1,0,1,0,1.
        req0_valid = 1'b1; req0_a = 4'd9; req0_b = 4'd4; req0_op = OpSub;
        req1_valid = 1'b1; req1_a = 4'd3; req1_b = 4'd8; req1_op = OpOr;
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) serve("alt_r0", 0, 4'd9, 4'd4, OpSub, 5'd5, 1'b0, 1'b0, t0);
            else            serve("alt_r1", 1, 4'd3, 4'd8, OpOr, 5'd11, 1'b0, 1'b0, t0);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Reset during EXEC of req1 15+15: aborted, all outputs cleared.
        req1_valid = 1'b1; req1_a = 4'd15; req1_b = 4'd15; req1_op = OpAdd;
        @(negedge clk);
        check_eq("abort_rdy1", req1_ready, 1'b1);
        @(posedge clk);
        #1;
        req1_valid = 1'b0;
        #2;
        rst_n      = 1'b0;
        req0_valid = 1'b1;
        #1;
        check_eq("abort_outs", {alu_a, alu_b, alu_op, resp_result, resp_zero}, '0);
        check_eq("abort_pulses", {req0_ready, req1_ready, resp0_valid, resp1_valid}, 4'b0000);
        @(negedge clk);
        req0_valid = 1'b0;
        rst_n      = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("abort_no_resp", {resp0_valid, resp1_valid, req0_ready, req1_ready}, 4'b0000);
        end
        @(posedge clk);
        #1;
        req0_valid = 1'b1; req0_a = 4'd15; req0_b = 4'd1; req0_op = OpAdd;
        serve("post_rst", 0, 4'd15, 4'd1, OpAdd, 5'd16, 1'b0, 1'b1, t0);

        // Requester 1 XOR 5^5 gives a zero result.
        req1_valid = 1'b1; req1_a = 4'd5; req1_b = 4'd5; req1_op = OpXor;
        serve("r1_xor", 1, 4'd5, 4'd5, OpXor, 5'd0, 1'b1, 1'b1, t0);

        // Unnamed op_code 3'b111 reaches the ALU unchanged.
        req0_valid = 1'b1; req0_a = 4'd6; req0_b = 4'd3; req0_op = 3'b111;
        serve("op7", 0, 4'd6, 4'd3, 3'b111, 5'd0, 1'b1, 1'b1, t0);

        // req0 alone three times leaves last_grant=0, so req1 wins contention.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd1; req0_op = OpAdd;
            serve("solo_r0", 0, 4'd1, 4'd1, OpAdd, 5'd2, 1'b0, 1'b1, t0);
        end
        req0_valid = 1'b1; req0_a = 4'd2; req0_b = 4'd2; req0_op = OpAdd;
        req1_valid = 1'b1; req1_a = 4'd3; req1_b = 4'd5; req1_op = OpSub;
        serve("rr_r1", 1, 4'd3, 4'd5, OpSub, 5'd30, 1'b0, 1'b1, t0);
        serve("rr_r0", 0, 4'd2, 4'd2, OpAdd, 5'd4, 1'b0, 1'b1, t0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
